// File: rtl/vga_reg_bank_decoder.sv
// PicoBlaze-to-VGA register bank: one-hot port decode, per-channel shadow registers,
// and frame-synchronous commit of shadows to the active registers seen by the VGA.
module vga_reg_bank_decoder #(
  parameter int N_REGS    = 9,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int SHADOW    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          port_id,
  input  logic                       write_strobe,
  input  logic [DATA_W-1:0]          out_port,
  input  logic                       frame_sync,
  output logic [DATA_W-1:0]          in_port,
  output logic [N_REGS-1:0]          enable,
  output logic [N_REGS-1:0]          wr_pulse,
  output logic [N_REGS*DATA_W-1:0]   reg_data,
  output logic                       commit_pending,
  output logic                       commit_done
);

  localparam int              CMT_ADDR = BASE_ADDR + N_REGS;
  localparam longint unsigned ADDR_MAX = (64'd1 << ADDR_W) - 64'd1;

  if ((N_REGS < 1) || (N_REGS > 32)) begin : g_bad_nregs
    $error("vga_reg_bank_decoder: N_REGS must be in 1..32");
  end
  if (longint'(BASE_ADDR) + longint'(N_REGS) > longint'(ADDR_MAX)) begin : g_bad_addr
    $error("vga_reg_bank_decoder: commit address does not fit in port_id");
  end

  logic [DATA_W-1:0] shadow_q [N_REGS];
  logic [DATA_W-1:0] shadow_d [N_REGS];
  logic [DATA_W-1:0] active_q [N_REGS];
  logic [DATA_W-1:0] active_d [N_REGS];
  logic [N_REGS-1:0] enable_q, enable_d;
  logic [N_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0] in_port_q, in_port_d;
  logic              commit_pending_q, commit_pending_d;
  logic              commit_done_q, commit_done_d;
  logic              fs_q, fs_d;

  logic [31:0]       port_ext_s;
  logic [N_REGS-1:0] dec_s;
  logic              cmt_hit_s;
  logic              cmt_write_s;
  logic              frame_edge_s;
  logic              transfer_s;

  assign port_ext_s = 32'(port_id);

  // Address decode, frame-edge detection and commit qualification.
  always_comb begin
    dec_s = '0;
    for (int i = 0; i < N_REGS; i++) begin
      dec_s[i] = (port_ext_s == 32'(BASE_ADDR + i));
    end
    cmt_hit_s    = (port_ext_s == 32'(CMT_ADDR));
    cmt_write_s  = (SHADOW != 0) && write_strobe && cmt_hit_s;
    frame_edge_s = frame_sync & ~fs_q;
    transfer_s   = (SHADOW != 0) && frame_edge_s && commit_pending_q;
  end

  // Next-state for the register arrays; a transfer copies the pre-write shadow value.
  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (write_strobe && dec_s[i]) begin
        shadow_d[i] = out_port;
      end else begin
        shadow_d[i] = shadow_q[i];
      end
      if (transfer_s) begin
        active_d[i] = shadow_q[i];
      end else if ((SHADOW == 0) && write_strobe && dec_s[i]) begin
        active_d[i] = out_port;
      end else begin
        active_d[i] = active_q[i];
      end
    end
  end

  // Next-state for the decode, read-back and commit handshake outputs.
  always_comb begin
    enable_d      = dec_s;
    wr_pulse_d    = write_strobe ? dec_s : '0;
    fs_d          = frame_sync;
    commit_done_d = transfer_s;
    in_port_d     = '0;
    for (int i = 0; i < N_REGS; i++) begin
      in_port_d = in_port_d | (dec_s[i] ? shadow_q[i] : '0);
    end
    in_port_d[0] = in_port_d[0] | (cmt_hit_s & commit_pending_q);
    // A request arriving with a transfer is queued for the following frame.
    if (cmt_write_s) begin
      commit_pending_d = 1'b1;
    end else if (transfer_s) begin
      commit_pending_d = 1'b0;
    end else begin
      commit_pending_d = commit_pending_q;
    end
  end

  // State register with synchronous reset; a pending commit is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      enable_q         <= '0;
      wr_pulse_q       <= '0;
      in_port_q        <= '0;
      commit_pending_q <= 1'b0;
      commit_done_q    <= 1'b0;
      fs_q             <= 1'b0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      enable_q         <= enable_d;
      wr_pulse_q       <= wr_pulse_d;
      in_port_q        <= in_port_d;
      commit_pending_q <= commit_pending_d;
      commit_done_q    <= commit_done_d;
      fs_q             <= fs_d;
    end
  end

  for (genvar g = 0; g < N_REGS; g++) begin : g_reg_data
    assign reg_data[g*DATA_W +: DATA_W] = active_q[g];
  end

  assign enable         = enable_q;
  assign wr_pulse       = wr_pulse_q;
  assign in_port        = in_port_q;
  assign commit_pending = commit_pending_q;
  assign commit_done    = commit_done_q;

endmodule

// File: tb/tb_vga_reg_bank_decoder.sv
// Bench for vga_reg_bank_decoder: a double-buffered default instance and a direct-write
// instance, both checked every cycle against a behavioural model of the register bank.
module tb_vga_reg_bank_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs;
  logic [7:0]  pa, pb;
  logic        wsa, wsb;
  logic [7:0]  da;
  logic [11:0] db;

  logic [7:0]  ina;
  logic [8:0]  ena, wra;
  logic [71:0] rda;
  logic        cpa, cda;
  logic [11:0] inb;
  logic [3:0]  enb, wrb;
  logic [47:0] rdb;
  logic        cpb, cdb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_reg_bank_decoder u_dut_a (
    .clk(clk), .reset(reset), .port_id(pa), .write_strobe(wsa), .out_port(da),
    .frame_sync(fs), .in_port(ina), .enable(ena), .wr_pulse(wra), .reg_data(rda),
    .commit_pending(cpa), .commit_done(cda)
  );

  vga_reg_bank_decoder #(
    .N_REGS(4), .DATA_W(12), .ADDR_W(8), .BASE_ADDR(16), .SHADOW(0)
  ) u_dut_b (
    .clk(clk), .reset(reset), .port_id(pb), .write_strobe(wsb), .out_port(db),
    .frame_sync(fs), .in_port(inb), .enable(enb), .wr_pulse(wrb), .reg_data(rdb),
    .commit_pending(cpb), .commit_done(cdb)
  );

  // Reference model: configuration 0 = instance A, 1 = instance B.
  int n_c [2] = '{9, 4};
  int b_c [2] = '{0, 16};
  int s_c [2] = '{1, 0};
  int m_sh  [2][9];
  int m_act [2][9];
  int m_en [2], m_wr [2], m_in [2];
  bit m_pend [2], m_done [2], m_fsd [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int c, input int p, input bit ws, input int d);
    bit hit, cmt, xfer;
    int idx;
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        m_sh[c][i]  = 0;
        m_act[c][i] = 0;
      end
      m_en[c] = 0; m_wr[c] = 0; m_in[c] = 0;
      m_pend[c] = 0; m_done[c] = 0; m_fsd[c] = 0;
    end else begin
      hit  = (p >= b_c[c]) && (p < b_c[c] + n_c[c]);
      cmt  = (p == b_c[c] + n_c[c]);
      idx  = hit ? p - b_c[c] : 0;
      m_en[c] = hit ? (1 << idx) : 0;
      m_wr[c] = (hit && ws) ? (1 << idx) : 0;
      m_in[c] = hit ? m_sh[c][idx] : (cmt ? int'(m_pend[c]) : 0);
      xfer = (s_c[c] != 0) && fs && !m_fsd[c] && m_pend[c];
      m_done[c] = xfer;
      if (xfer) m_act[c] = m_sh[c];
      if (hit && ws) begin
        m_sh[c][idx] = d;
        if (s_c[c] == 0) m_act[c][idx] = d;
      end
      if (cmt && ws && (s_c[c] != 0)) m_pend[c] = 1'b1;
      else if (xfer) m_pend[c] = 1'b0;
      m_fsd[c] = fs;
    end
  endtask

  task automatic compare_all();
    check("a_enable", ena, m_en[0]);
    check("a_wr_pulse", wra, m_wr[0]);
    check("a_in_port", ina, m_in[0]);
    check("a_pending", cpa, m_pend[0]);
    check("a_done", cda, m_done[0]);
    for (int i = 0; i < 9; i++) check($sformatf("a_reg%0d", i), rda[i*8 +: 8], m_act[0][i]);
    check("b_enable", enb, m_en[1]);
    check("b_wr_pulse", wrb, m_wr[1]);
    check("b_in_port", inb, m_in[1]);
    check("b_pending", cpb, m_pend[1]);
    check("b_done", cdb, m_done[1]);
    for (int i = 0; i < 4; i++) check($sformatf("b_reg%0d", i), rdb[i*12 +: 12], m_act[1][i]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0, int'(pa), wsa, int'(da));
    model_step(1, int'(pb), wsb, int'(db));
    #1;
    compare_all();
  endtask

  task automatic wr_a(input logic [7:0] a, input logic [7:0] d);
    pa = a; da = d; wsa = 1'b1;
    step();
    wsa = 1'b0;
  endtask

  task automatic wr_b(input logic [7:0] a, input logic [11:0] d);
    pb = a; db = d; wsb = 1'b1;
    step();
    wsb = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fs = 1'b1;
    pa = 8'h00; pb = 8'h00; wsa = 1'b0; wsb = 1'b0; da = 8'h00; db = 12'h000;
    step(); step();
    check("rst_reg_data", rda, 72'h0);
    check("rst_enable", ena, 9'h000);
    reset = 1'b0;
    step(); step();
    check("no_xfer_after_rst", cda, 1'b0);

    // Decode sweep over the channel range, the commit address and a stray address.
    for (int p = 0; p <= 9; p++) begin
      pa = 8'(p);
      step();
    end
    pa = 8'd3; step();
    check("decode3", ena, 9'h008);
    pa = 8'h20; step();
    check("decode_out", ena, 9'h000);

    fs = 1'b0; step();
    wr_a(8'd3, 8'h5A);
    check("wp3", wra, 9'h008);
    check("a3_held", rda[31:24], 8'h00);
    step();
    check("wp3_clear", wra, 9'h000);
    wr_a(8'd9, 8'hFF);
    check("pend_set", cpa, 1'b1);
    fs = 1'b1; step();
    check("a3_commit", rda[31:24], 8'h5A);
    check("done_pulse", cda, 1'b1);
    step();
    check("done_once", cda, 1'b0);

    // Shadow write on a transfer edge, then a commit write on a transfer edge.
    fs = 1'b0;
    wr_a(8'd0, 8'h11);
    wr_a(8'd9, 8'h00);
    fs = 1'b1;
    wr_a(8'd0, 8'h22);
    check("coll_active_old", rda[7:0], 8'h11);
    pa = 8'd0; step();
    check("coll_shadow_new", ina, 8'h22);
    wr_a(8'd9, 8'h00);
    fs = 1'b0; step();
    fs = 1'b1;
    wr_a(8'd9, 8'h00);
    check("coll_active_new", rda[7:0], 8'h22);
    check("coll_pend_kept", cpa, 1'b1);
    fs = 1'b0; step();
    fs = 1'b1; step();
    check("queued_xfer", cda, 1'b1);

    // Several requests collapse into one transfer; commit on an idle frame edge only sets pending.
    fs = 1'b0;
    wr_a(8'd9, 8'h00); wr_a(8'd9, 8'h00); wr_a(8'd9, 8'h00);
    fs = 1'b1; step(); step();
    check("collapse_single", cda, 1'b0);
    fs = 1'b0; step();
    fs = 1'b1;
    wr_a(8'd9, 8'h00);
    check("cmt_on_idle_edge", cpa, 1'b1);

    // Reset while a commit is pending.
    reset = 1'b1; step();
    reset = 1'b0; fs = 1'b0; step();
    fs = 1'b1; step();
    check("rst_discard", cda, 1'b0);
    check("rst_regs_zero", rda, 72'h0);

    // Direct-write instance.
    wr_b(8'h12, 12'hABC);
    check("b_direct", rdb[35:24], 12'hABC);
    wr_b(8'h14, 12'h001);
    check("b_no_commit", cpb, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      pa  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      wsa = 1'($urandom_range(0, 1));
      da  = 8'($urandom);
      pb  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(14, 21));
      wsb = 1'($urandom_range(0, 1));
      db  = 12'($urandom);
      if ($urandom_range(0, 5) == 0) fs = ~fs;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
